clock_divider_multi: RTL and testbench

//  NUM_CH-channel programmable clock divider / tick generator. Successor to the single fixed 1 Hz divider.

---
 rtl/clock_divider_multi.sv | 111 +++++++++++
 tb/tb_clock_divider_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable tick / 50%-duty toggle generator running off the system clock.
// Optional `SYNC_RESTART_EN adds a sync_restart input that phase-aligns every channel.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25_000_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef SYNC_RESTART_EN
  input  logic              sync_restart,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic restart;
`ifdef SYNC_RESTART_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clko_q, clko_d;
    logic             wr_hit;
    logic             wrap;

    // Out-of-range channel indices never match any channel, so they are dropped.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));
    assign wrap   = (cnt_q == act_q - CNT_W'(1));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      clko_d = clko_q;
      if (restart) begin
        cnt_d  = '0;
        clko_d = 1'b0;
        if (pend_q) act_d = shd_q;
        pend_d = 1'b0;
      end else if (act_q == '0) begin
        // Halted channel picks up a pending divisor regardless of en.
        cnt_d = '0;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
        if (wr_hit) begin
          shd_d  = wr_div;
          pend_d = 1'b1;
        end
      end else if (en && wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clko_d = ~clko_q;
        if (wr_hit) begin
          act_d  = wr_div;
          shd_d  = wr_div;
          pend_d = 1'b0;
        end else if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        if (en) cnt_d = cnt_q + CNT_W'(1);
        if (wr_hit) begin
          shd_d  = wr_div;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DIV_RST;
        shd_q  <= DIV_RST;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        clko_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        clko_q <= clko_d;
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clko_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (3 channels, 8-bit counters, default divisor 3).
// Expected tick/clk_out vectors are queued per step and compared after each edge.
module tb_clock_divider_multi;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic              sync_restart = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  clock_divider_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
`ifdef SYNC_RESTART_EN
    .sync_restart(sync_restart),
`endif
    .tick(tick),
    .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] co;
    string             tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push(input logic [2:0] t, input logic [2:0] c, input string tag);
    exp_t e;
    e.tk  = t;
    e.co  = c;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (tick === e.tk) else begin
      n_errors++;
      $error("FAIL %s tick: observed %b expected %b", e.tag, tick, e.tk);
    end
    n_checks++;
    assert (clk_out === e.co) else begin
      n_errors++;
      $error("FAIL %s clk_out: observed %b expected %b", e.tag, clk_out, e.co);
    end
  endtask

  task automatic cyc(input logic [2:0] t, input logic [2:0] c, input string tag);
    push(t, c, tag);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic set_wr(input logic [1:0] ch, input logic [CNT_W-1:0] dv);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = dv;
  endtask

  task automatic clr_wr();
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
  endtask

  // Asserts reset away from any clock edge, checks the outputs cleared without an edge,
  // then releases reset just after a rising edge with en=1.
  task automatic apply_reset(input string tag);
    rst_n        = 1'b0;
    en           = 1'b0;
    sync_restart = 1'b0;
    clr_wr();
    push(3'b000, 3'b000, tag);
    #2;
    compare_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    #1;
    apply_reset("rst0");

    // Default divisor: ticks on edges 3,6,9, clk_out period 6
    cyc(3'b000, 3'b000, "t1_e1");
    cyc(3'b000, 3'b000, "t1_e2");
    cyc(3'b111, 3'b111, "t1_e3");
    cyc(3'b000, 3'b111, "t1_e4");
    cyc(3'b000, 3'b111, "t1_e5");
    cyc(3'b111, 3'b000, "t1_e6");
    cyc(3'b000, 3'b000, "t1_e7");
    cyc(3'b000, 3'b000, "t1_e8");
    cyc(3'b111, 3'b111, "t1_e9");

    // Shadowed write to ch1, direct write on ch0 wrap edge
    apply_reset("rst_t2");
    set_wr(2'd1, 8'd5);
    cyc(3'b000, 3'b000, "t2_e1");
    clr_wr();
    cyc(3'b000, 3'b000, "t2_e2");
    cyc(3'b111, 3'b111, "t2_e3");
    cyc(3'b000, 3'b111, "t2_e4");
    cyc(3'b000, 3'b111, "t2_e5");
    set_wr(2'd0, 8'd4);
    cyc(3'b101, 3'b010, "t2_e6");
    clr_wr();
    cyc(3'b000, 3'b010, "t2_e7");
    cyc(3'b010, 3'b000, "t2_e8");
    cyc(3'b100, 3'b100, "t2_e9");
    cyc(3'b001, 3'b101, "t2_e10");
    cyc(3'b000, 3'b101, "t2_e11");
    cyc(3'b100, 3'b001, "t2_e12");
    cyc(3'b010, 3'b011, "t2_e13");
    cyc(3'b001, 3'b010, "t2_e14");

    // Halt ch0 with div 0, resume with div 2, then div 1
    apply_reset("rst_t3");
    set_wr(2'd0, 8'd0);
    cyc(3'b000, 3'b000, "t3_e1");
    clr_wr();
    cyc(3'b000, 3'b000, "t3_e2");
    cyc(3'b111, 3'b111, "t3_e3");
    cyc(3'b000, 3'b111, "t3_e4");
    set_wr(2'd0, 8'd2);
    cyc(3'b000, 3'b111, "t3_e5");
    clr_wr();
    cyc(3'b110, 3'b001, "t3_e6");
    cyc(3'b000, 3'b001, "t3_e7");
    cyc(3'b001, 3'b000, "t3_e8");
    cyc(3'b110, 3'b110, "t3_e9");
    set_wr(2'd0, 8'd1);
    cyc(3'b001, 3'b111, "t3_e10");
    clr_wr();
    cyc(3'b001, 3'b110, "t3_e11");
    cyc(3'b111, 3'b001, "t3_e12");
    cyc(3'b001, 3'b000, "t3_e13");

    // en=0 freeze with writes: ch2 div 2 accepted, wr_ch=3 ignored
    apply_reset("rst_t4");
    cyc(3'b000, 3'b000, "t4_e1");
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) set_wr(2'd2, 8'd2);
      else if (k == 5) set_wr(2'd3, 8'd7);
      else clr_wr();
      cyc(3'b000, 3'b000, $sformatf("t4_off%0d", k));
    end
    clr_wr();
    en = 1'b1;
    cyc(3'b000, 3'b000, "t4_r1");
    cyc(3'b111, 3'b111, "t4_r2");
    cyc(3'b000, 3'b111, "t4_r3");
    cyc(3'b100, 3'b011, "t4_r4");
    cyc(3'b011, 3'b000, "t4_r5");
    cyc(3'b100, 3'b100, "t4_r6");
    cyc(3'b000, 3'b100, "t4_r7");
    cyc(3'b111, 3'b011, "t4_r8");

    // Mid-period async reset at cnt=2 restores default divisors
    apply_reset("rst_t5a");
    set_wr(2'd1, 8'd6);
    cyc(3'b000, 3'b000, "t5_e1");
    clr_wr();
    cyc(3'b000, 3'b000, "t5_e2");
    cyc(3'b111, 3'b111, "t5_e3");
    cyc(3'b000, 3'b111, "t5_e4");
    cyc(3'b000, 3'b111, "t5_e5");
    apply_reset("t5_async_rst");
    cyc(3'b000, 3'b000, "t5_p1");
    cyc(3'b000, 3'b000, "t5_p2");
    cyc(3'b111, 3'b111, "t5_p3");
    cyc(3'b000, 3'b111, "t5_p4");
    cyc(3'b000, 3'b111, "t5_p5");
    cyc(3'b111, 3'b000, "t5_p6");

`ifdef SYNC_RESTART_EN
    // sync_restart overrides en=0, applies pending ch1 div 4, aligns phases
    apply_reset("rst_t6");
    cyc(3'b000, 3'b000, "t6_e1");
    cyc(3'b000, 3'b000, "t6_e2");
    cyc(3'b111, 3'b111, "t6_e3");
    set_wr(2'd1, 8'd4);
    cyc(3'b000, 3'b111, "t6_e4");
    clr_wr();
    en           = 1'b0;
    sync_restart = 1'b1;
    cyc(3'b000, 3'b000, "t6_sync");
    sync_restart = 1'b0;
    en           = 1'b1;
    cyc(3'b000, 3'b000, "t6_s1");
    cyc(3'b000, 3'b000, "t6_s2");
    cyc(3'b101, 3'b101, "t6_s3");
    cyc(3'b010, 3'b111, "t6_s4");
    cyc(3'b000, 3'b111, "t6_s5");
    cyc(3'b101, 3'b010, "t6_s6");
    cyc(3'b000, 3'b010, "t6_s7");
    cyc(3'b010, 3'b000, "t6_s8");
    cyc(3'b101, 3'b101, "t6_s9");
    cyc(3'b000, 3'b101, "t6_s10");
    cyc(3'b000, 3'b101, "t6_s11");
    cyc(3'b111, 3'b010, "t6_s12");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
